// File: rtl/sevseg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_data/wr_dp (bus write),
//   en_mask (per-digit enable), seg/dp/an (active-low drive), digit_idx,
//   frame_pulse (one cycle after the last slot of each scan).
module sevseg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [4*N_DIGITS-1:0]         wr_data,
    input  logic [N_DIGITS-1:0]           wr_dp,
    input  logic [N_DIGITS-1:0]           en_mask,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [N_DIGITS-1:0]           an,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_pulse
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] disp_q, disp_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [IW-1:0]         digit_idx_q, digit_idx_d;
    logic                  frame_pulse_q, frame_pulse_d;

    logic                  frame_end;
    logic                  blank;
    logic [3:0]            nib;

    // Active-high segment bits [6:0]; inverted at the pin.
    function automatic logic [6:0] seg_pattern(input logic [3:0] n);
        logic [6:0] p;
        unique case (n)
            4'h0: p = 7'b1110111;
            4'h1: p = 7'b1000001;
            4'h2: p = 7'b1101110;
            4'h3: p = 7'b1101011;
            4'h4: p = 7'b1011001;
            4'h5: p = 7'b0111011;
            4'h6: p = 7'b0111111;
            4'h7: p = 7'b1100001;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1111001;
            4'hA: p = 7'b1111101;
            4'hB: p = 7'b0011111;
            4'hC: p = 7'b0110110;
            4'hD: p = 7'b1001111;
            4'hE: p = 7'b0111110;
            default: p = 7'b0111100;
        endcase
        return p;
    endfunction

    always_comb begin
        frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // Writes park in pend; the display only swaps at the frame boundary.
        // A write landing on the boundary cycle goes straight to disp.
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (frame_end) begin
            if (wr_en) begin
                disp_d    = wr_data;
                disp_dp_d = wr_dp;
            end else if (pend_valid_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (wr_en) begin
            pend_d       = wr_data;
            pend_dp_d    = wr_dp;
            pend_valid_d = 1'b1;
        end

        nib   = disp_q[{idx_q, 2'b00} +: 4];
        blank = (cnt_q < BLANK_C) || !en_mask[idx_q];

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = ~seg_pattern(nib);
            dp_d        = ~disp_dp_q[idx_q];
        end
        digit_idx_d   = idx_q;
        frame_pulse_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            disp_q        <= '0;
            disp_dp_q     <= '0;
            pend_q        <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
            digit_idx_q   <= '0;
            frame_pulse_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            disp_q        <= disp_d;
            disp_dp_q     <= disp_dp_d;
            pend_q        <= pend_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            digit_idx_q   <= digit_idx_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign digit_idx   = digit_idx_q;
    assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver (4 digits, 8-cycle slots, 2 blank).
// Per-cycle reference model plus vector table and corner-case sequences.
module tb_sevseg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int FR  = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic [3:0]  en_mask = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_pulse;

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_dp(wr_dp), .en_mask(en_mask), .seg(seg), .dp(dp), .an(an),
        .digit_idx(digit_idx), .frame_pulse(frame_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Model: s = steps since reset; the display is whatever was most recently
    // written at or before the last frame-end cycle.
    int          s;
    logic [15:0] latest, shown;
    logic [3:0]  latest_dp, shown_dp;
    logic [14:0] exp_v;
    logic [6:0]  pat [16];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  mask;
        logic [27:0] segs;
        logic [3:0]  dps;
        logic [15:0] ans;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [14:0] model_out(input int st, input logic [3:0] m);
        int         c, i;
        logic [3:0] an_e, nib;
        logic [6:0] sg;
        logic       dpe;
        c = st % DIV;
        i = (st / DIV) % N;
        an_e = 4'hF;
        sg   = 7'h7F;
        dpe  = 1'b1;
        if (c >= BLK && m[i]) begin
            an_e = 4'hF & ~(4'b0001 << i);
            nib  = shown[4*i +: 4];
            sg   = ~pat[nib];
            dpe  = ~shown_dp[i];
        end
        return {(st % FR == FR - 1), 2'(i), an_e, dpe, sg};
    endfunction

    task automatic step(input logic we, input logic [15:0] d, input logic [3:0] p);
        wr_en = we;
        wr_data = d;
        wr_dp = p;
        exp_v = model_out(s, en_mask);
        if (we) begin
            latest = d;
            latest_dp = p;
        end
        if (s % FR == FR - 1) begin
            shown = latest;
            shown_dp = latest_dp;
        end
        s++;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("cycle", {17'd0, frame_pulse, digit_idx, an, dp, seg}, {17'd0, exp_v});
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic goto_ph(input int ph);
        while (s % FR != ph) idle();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wr_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("reset_out", {17'd0, frame_pulse, digit_idx, an, dp, seg},
            {17'd0, 1'b0, 2'd0, 4'hF, 1'b1, 7'h7F});
        s = 0;
        latest = '0;
        shown = '0;
        latest_dp = '0;
        shown_dp = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, p1, cnt_bad, ph;

        pat[0]  = 7'b1110111; pat[1]  = 7'b1000001;
        pat[2]  = 7'b1101110; pat[3]  = 7'b1101011;
        pat[4]  = 7'b1011001; pat[5]  = 7'b0111011;
        pat[6]  = 7'b0111111; pat[7]  = 7'b1100001;
        pat[8]  = 7'b1111111; pat[9]  = 7'b1111001;
        pat[10] = 7'b1111101; pat[11] = 7'b0011111;
        pat[12] = 7'b0110110; pat[13] = 7'b1001111;
        pat[14] = 7'b0111110; pat[15] = 7'b0111100;

        vecs[0] = '{16'h3210, 4'h0, 4'hF,
                    {7'h14, 7'h11, 7'h3E, 7'h08}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[1] = '{16'hFEDC, 4'h0, 4'hF,
                    {7'h43, 7'h41, 7'h30, 7'h49}, 4'hF, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[2] = '{16'h9876, 4'b1010, 4'hF,
                    {7'h06, 7'h00, 7'h1E, 7'h40}, 4'b0101, {4'h7, 4'hB, 4'hD, 4'hE}};
        vecs[3] = '{16'h5B4A, 4'b0001, 4'b0101,
                    {7'h7F, 7'h60, 7'h7F, 7'h02}, 4'b1110, {4'hF, 4'hB, 4'hF, 4'hE}};

        // Reset and first blanking cycles
        do_reset(3);
        idle();
        chk("blank_an0", {28'd0, an}, 32'hF);
        idle();
        chk("blank_an1", {28'd0, an}, 32'hF);

        // Frame pulse position and period
        p0 = -1;
        p1 = -1;
        while (s < 70) begin
            idle();
            if (frame_pulse === 1'b1) begin
                if (p0 < 0) p0 = s - 1;
                else if (p1 < 0) p1 = s - 1;
            end
        end
        chk("fp_first", p0, 31);
        chk("fp_gap", p1 - p0, FR);

        // Vector table: write mid-frame, check each slot of the next frame
        foreach (vecs[v]) begin
            en_mask = vecs[v].mask;
            goto_ph(8);
            step(1'b1, vecs[v].data, vecs[v].dpv);
            for (int d = 0; d < N; d++) begin
                goto_ph(d * DIV + 4);
                idle();
                chk("tbl_an", {28'd0, an}, {28'd0, vecs[v].ans[4*d +: 4]});
                chk("tbl_seg", {25'd0, seg}, {25'd0, vecs[v].segs[7*d +: 7]});
                chk("tbl_dp", {31'd0, dp}, {31'd0, vecs[v].dps[d]});
            end
        end
        en_mask = 4'hF;

        // Tear-free: write during digit 1 slot, rest of frame keeps old digits
        goto_ph(8);
        step(1'b1, 16'h3210, 4'h0);
        goto_ph(8);
        step(1'b1, 16'hFEDC, 4'h0);
        goto_ph(20);
        idle();
        chk("tear_d2", {25'd0, seg}, 32'h11);
        goto_ph(28);
        idle();
        chk("tear_d3", {25'd0, seg}, 32'h14);
        goto_ph(4);
        idle();
        chk("tear_new_d0", {25'd0, seg}, 32'h49);

        // Write on the frame-end cycle overrides an older pending write
        goto_ph(10);
        step(1'b1, 16'h1111, 4'h0);
        goto_ph(31);
        step(1'b1, 16'hAAAA, 4'h0);
        cnt_bad = 0;
        for (int k = 0; k < FR; k++) begin
            ph = s % FR;
            idle();
            if (seg === 7'h3E) cnt_bad++;
            if (ph % DIV == 4) chk("simul_a", {25'd0, seg}, 32'h02);
        end
        chk("simul_no1", cnt_bad, 0);

        // Reset mid-frame discards the pending write
        goto_ph(5);
        step(1'b1, 16'h5555, 4'h0);
        goto_ph(20);
        do_reset(3);
        cnt_bad = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            ph = s % FR;
            idle();
            if (seg === 7'h44) cnt_bad++;
            if (ph % DIV == 4) chk("rst_zero", {25'd0, seg}, 32'h08);
        end
        chk("rst_no5", cnt_bad, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) en_mask = 4'($urandom);
            if (k == 1500) do_reset(2);
            step($urandom_range(11) == 0, 16'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
